// File: rtl/ring_led_sequencer.sv
// rtl/ring_led_sequencer.sv - command-driven rotating LED ring sequencer
module ring_led_sequencer #(
  parameter int WIDTH  = 4,
  parameter int DIV_W  = 8,
  parameter int STEP_W = 8
) (
  input  logic              CLK,
  input  logic              clr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [WIDTH-1:0]  cmd_data,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0]  cmd_div,
  output logic [WIDTH-1:0]  LED,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_RUN_L = 2'b01;
  localparam logic [1:0] OP_RUN_R = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  typedef enum logic {IDLE, RUN} state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    led_q, led_d;
  logic [DIV_W-1:0]    presc_q, presc_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic                dir_right_q, dir_right_d;
  logic                done_q, done_d;
  logic                accept;
  logic [WIDTH-1:0]    led_rot;

  // Only STOP can break into a running sequence; everything else waits for IDLE.
  assign cmd_ready = (state_q == IDLE) || (cmd_op == OP_STOP);
  assign accept    = cmd_valid && cmd_ready;

  assign LED  = led_q;
  assign busy = (state_q == RUN);
  assign done = done_q;

  // Next pattern if this edge is a step, in the latched direction.
  always_comb begin
    led_rot = led_q;
    if (dir_right_q) led_rot = {led_q[0], led_q[WIDTH-1:1]};
    else             led_rot = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
  end

  // Next-state logic: command handling in IDLE, prescaled stepping in RUN.
  always_comb begin
    state_d     = state_q;
    led_d       = led_q;
    presc_d     = presc_q;
    div_d       = div_q;
    steps_d     = steps_q;
    dir_right_d = dir_right_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (cmd_op)
            OP_LOAD: led_d = cmd_data;
            OP_RUN_L, OP_RUN_R: begin
              dir_right_d = (cmd_op == OP_RUN_R);
              steps_d     = cmd_steps;
              div_d       = cmd_div;
              presc_d     = '0;
              state_d     = RUN;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        if (accept) begin
          // STOP takes priority over a step falling on the same edge.
          state_d = IDLE;
          presc_d = '0;
        end else if (presc_q == div_q) begin
          led_d   = led_rot;
          presc_d = '0;
          if (steps_q != '0) begin
            steps_d = steps_q - STEP_W'(1);
            if (steps_q == STEP_W'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end else begin
          presc_d = presc_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge CLK or negedge clr) begin
    if (!clr) begin
      state_q     <= IDLE;
      led_q       <= WIDTH'(1);
      presc_q     <= '0;
      div_q       <= '0;
      steps_q     <= '0;
      dir_right_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      led_q       <= led_d;
      presc_q     <= presc_d;
      div_q       <= div_d;
      steps_q     <= steps_d;
      dir_right_q <= dir_right_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_ring_led_sequencer.sv
// tb/tb_ring_led_sequencer.sv - directed self-checking bench for ring_led_sequencer
module tb_ring_led_sequencer;

  logic       CLK = 1'b0;
  logic       clr;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [7:0] cmd_steps;
  logic [7:0] cmd_div;
  logic [3:0] LED;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  ring_led_sequencer #(.WIDTH(4), .DIV_W(8), .STEP_W(8)) dut (
    .CLK       (CLK),
    .clr       (clr),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_steps (cmd_steps),
    .cmd_div   (cmd_div),
    .LED       (LED),
    .busy      (busy),
    .done      (done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic present(input logic [1:0] op, input logic [3:0] data,
                         input logic [7:0] steps, input logic [7:0] div);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_steps = steps;
    cmd_div   = div;
  endtask

  task automatic idle_cmd();
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] led_e,
                         input logic busy_e, input logic done_e);
    check({tag, ".led"},  {28'd0, LED},  {28'd0, led_e});
    check({tag, ".busy"}, {31'd0, busy}, {31'd0, busy_e});
    check({tag, ".done"}, {31'd0, done}, {31'd0, done_e});
  endtask

  initial begin
    clr = 1'b1;
    idle_cmd();
    cmd_data = '0; cmd_steps = '0; cmd_div = '0;
    #2;
    clr = 1'b0;
    #1;
    chk_out("rst", 4'b0001, 1'b0, 1'b0);
    check("rst.ready", {31'd0, cmd_ready}, 32'd1);
    #1;
    clr = 1'b1;

    // LOAD 0011 then RUN_L steps=3 div=0
    tick();
    present(2'b00, 4'b0011, 8'd0, 8'd0);
    tick();
    idle_cmd();
    check("load.led", {28'd0, LED}, 32'h3);
    present(2'b01, 4'b0000, 8'd3, 8'd0);
    tick();
    idle_cmd();
    chk_out("rl.e0", 4'b0011, 1'b1, 1'b0);
    tick(); chk_out("rl.e1", 4'b0110, 1'b1, 1'b0);
    tick(); chk_out("rl.e2", 4'b1100, 1'b1, 1'b0);
    tick(); chk_out("rl.e3", 4'b1001, 1'b0, 1'b1);
    tick(); chk_out("rl.hold", 4'b1001, 1'b0, 1'b0);

    // LOAD 1000 then RUN_R steps=2 div=2
    present(2'b00, 4'b1000, 8'd0, 8'd0);
    tick();
    present(2'b10, 4'b0000, 8'd2, 8'd2);
    tick();
    idle_cmd();
    chk_out("rr.e0", 4'b1000, 1'b1, 1'b0);
    tick(); chk_out("rr.e1", 4'b1000, 1'b1, 1'b0);
    tick(); chk_out("rr.e2", 4'b1000, 1'b1, 1'b0);
    tick(); chk_out("rr.e3", 4'b0100, 1'b1, 1'b0);
    tick(); chk_out("rr.e4", 4'b0100, 1'b1, 1'b0);
    tick(); chk_out("rr.e5", 4'b0100, 1'b1, 1'b0);
    tick(); chk_out("rr.e6", 4'b0010, 1'b0, 1'b1);

    // LOAD 0001, continuous RUN_L div=1, STOP on a step edge
    present(2'b00, 4'b0001, 8'd0, 8'd0);
    tick();
    present(2'b01, 4'b0000, 8'd0, 8'd1);
    tick();
    idle_cmd();
    chk_out("cont.e0", 4'b0001, 1'b1, 1'b0);
    tick(); chk_out("cont.e1", 4'b0001, 1'b1, 1'b0);
    tick(); chk_out("cont.e2", 4'b0010, 1'b1, 1'b0);
    tick(); tick(); chk_out("cont.e4", 4'b0100, 1'b1, 1'b0);
    tick(); tick(); chk_out("cont.e6", 4'b1000, 1'b1, 1'b0);
    tick(); chk_out("cont.e7", 4'b1000, 1'b1, 1'b0);
    present(2'b11, 4'b0000, 8'd0, 8'd0);
    #1;
    check("stop.ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    idle_cmd();
    chk_out("stop.e8", 4'b1000, 1'b0, 1'b0);
    tick(); chk_out("stop.e9", 4'b1000, 1'b0, 1'b0);

    // LOAD 0001, RUN_L steps=2 div=0 with a LOAD held during the run
    present(2'b00, 4'b0001, 8'd0, 8'd0);
    tick();
    present(2'b01, 4'b0000, 8'd2, 8'd0);
    tick();
    present(2'b00, 4'b0101, 8'd0, 8'd0);
    #1;
    check("bp.ready0", {31'd0, cmd_ready}, 32'd0);
    tick();
    chk_out("bp.e1", 4'b0010, 1'b1, 1'b0);
    check("bp.ready1", {31'd0, cmd_ready}, 32'd0);
    tick();
    chk_out("bp.e2", 4'b0100, 1'b0, 1'b1);
    check("bp.ready2", {31'd0, cmd_ready}, 32'd1);
    tick();
    idle_cmd();
    chk_out("bp.e3", 4'b0101, 1'b0, 1'b0);

    // Continuous RUN_L div=3, async clear mid-prescale, then RUN_R steps=1
    present(2'b01, 4'b0000, 8'd0, 8'd3);
    tick();
    idle_cmd();
    tick();
    chk_out("ar.pre", 4'b0101, 1'b1, 1'b0);
    #2;
    clr = 1'b0;
    #1;
    chk_out("ar.rst", 4'b0001, 1'b0, 1'b0);
    check("ar.ready", {31'd0, cmd_ready}, 32'd1);
    #1;
    clr = 1'b1;
    present(2'b10, 4'b0000, 8'd1, 8'd0);
    tick();
    idle_cmd();
    chk_out("ar.e0", 4'b0001, 1'b1, 1'b0);
    tick(); chk_out("ar.e1", 4'b1000, 1'b0, 1'b1);
    tick(); chk_out("ar.e2", 4'b1000, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
